// File: rtl/vga_burst_fetch.sv
// vga_burst_fetch: fetches the frame buffer in fixed-length bursts into a word
// FIFO and streams it out as RGB332 pixels, low byte first, one per PixEn.
module vga_burst_fetch #(
  parameter int ADDR_W          = 23,
  parameter int BURST_LEN       = 32,
  parameter int WORDS_PER_FRAME = 153600,
  parameter int FIFO_DEPTH      = 64,
  parameter int FRAME_BASE      = 0
) (
  input  logic              Clk_25M,
  input  logic              Rst,
  input  logic              FrameStart,
  input  logic              PixEn,
  output logic [7:0]        Pixel,
  output logic              burst_req,
  output logic [ADDR_W-1:0] burst_addr,
  input  logic              burst_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              underflow
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BURST_LEN);

  typedef enum logic [2:0] {IDLE, REQ, RECV, WAIT, DRAIN} state_t;
  state_t state, stateNext;

  logic [ADDR_W-1:0] fetched;
  logic [BW-1:0]     beatCnt;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]     wrPtr, rdPtr;
  logic [PW:0]       count, reserved, freeSpace;
  logic              byteSel, accept, lastBeat, spaceOk, frameDone;
  logic              fifoWr, fifoPop, haveWord;

  assign accept    = (state == REQ) && burst_ack;
  assign lastBeat  = rd_valid && (beatCnt == BW'(BURST_LEN - 1));
  // Slots still owed to the burst in flight count as occupied, so a new
  // request is only made when a whole burst is guaranteed to fit.
  assign reserved  = (state == RECV) ? ((PW+1)'(BURST_LEN) - (PW+1)'(beatCnt)) : '0;
  assign freeSpace = (PW+1)'(FIFO_DEPTH) - count - reserved;
  assign spaceOk   = freeSpace >= (PW+1)'(BURST_LEN);
  assign frameDone = fetched == ADDR_W'(WORDS_PER_FRAME);
  assign haveWord  = count != '0;
  // A FrameStart flush overrides any write or pop in the same cycle.
  assign fifoWr    = (state == RECV) && rd_valid && !FrameStart;
  assign fifoPop   = PixEn && haveWord && byteSel && !FrameStart;

  assign burst_req  = (state == REQ);
  assign burst_addr = burst_req ? ADDR_W'(FRAME_BASE) + fetched : '0;

  // State register.
  always_ff @(posedge Clk_25M) begin
    if (Rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic; FrameStart restarts the frame from any state.
  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:  if (FrameStart) stateNext = REQ;
      // An ack coinciding with FrameStart still commits the controller to a
      // full burst of stale data, so it must be drained.
      REQ:   if (burst_ack) stateNext = FrameStart ? DRAIN : RECV;
      RECV: begin
        if (lastBeat) begin
          if (FrameStart)     stateNext = REQ;
          else if (frameDone) stateNext = IDLE;
          else if (spaceOk)   stateNext = REQ;
          else                stateNext = WAIT;
        end else if (FrameStart) begin
          stateNext = DRAIN;
        end
      end
      WAIT:  if (FrameStart || spaceOk) stateNext = REQ;
      DRAIN: if (lastBeat) stateNext = REQ;
      default: stateNext = IDLE;
    endcase
  end

  // Burst bookkeeping: words requested this frame and beats of the current burst.
  always_ff @(posedge Clk_25M) begin
    if (Rst) begin
      fetched <= '0;
      beatCnt <= '0;
    end else begin
      if (FrameStart)  fetched <= '0;
      else if (accept) fetched <= fetched + ADDR_W'(BURST_LEN);
      if (accept)
        beatCnt <= '0;
      else if ((state == RECV || state == DRAIN) && rd_valid)
        beatCnt <= beatCnt + BW'(1);
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge Clk_25M) begin
    if (fifoWr) mem[wrPtr] <= rd_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge Clk_25M) begin
    if (Rst || FrameStart) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (fifoWr)  wrPtr <= wrPtr + PW'(1);
      if (fifoPop) rdPtr <= rdPtr + PW'(1);
      count <= count + (PW+1)'(fifoWr) - (PW+1)'(fifoPop);
    end
  end

  // Pixel output: byte unpack from the FIFO head, sticky underflow on empty.
  always_ff @(posedge Clk_25M) begin
    if (Rst) begin
      Pixel     <= 8'h00;
      byteSel   <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (PixEn) begin
        if (haveWord) begin
          Pixel <= byteSel ? mem[rdPtr][15:8] : mem[rdPtr][7:0];
        end else begin
          Pixel     <= 8'h00;
          underflow <= 1'b1;
        end
      end
      if (FrameStart)              byteSel <= 1'b0;
      else if (PixEn && haveWord)  byteSel <= ~byteSel;
    end
  end

endmodule

// File: tb/tb_vga_burst_fetch.sv
// tb_vga_burst_fetch: randomized controller + word-queue reference model with
// a scoreboard monitor for pixels and burst addresses.
module tb_vga_burst_fetch;
  localparam int ADDR_W = 23;
  localparam int BL     = 32;
  localparam int WPF    = 2560;
  localparam int DEPTH  = 64;
  localparam int BASE   = 0;

  logic              clk = 1'b0;
  logic              Rst, FrameStart, PixEn, burst_ack, rd_valid;
  logic [15:0]       rd_data;
  logic [7:0]        Pixel;
  logic              burst_req, underflow;
  logic [ADDR_W-1:0] burst_addr;

  always #5 clk = ~clk;

  vga_burst_fetch #(.ADDR_W(ADDR_W), .BURST_LEN(BL), .WORDS_PER_FRAME(WPF),
                    .FIFO_DEPTH(DEPTH), .FRAME_BASE(BASE)) dut (
    .Clk_25M(clk), .Rst(Rst), .FrameStart(FrameStart), .PixEn(PixEn),
    .Pixel(Pixel), .burst_req(burst_req), .burst_addr(burst_addr),
    .burst_ack(burst_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .underflow(underflow));

  int checks = 0, failures = 0;

  typedef struct { logic [7:0] px; logic uf; } pix_t;
  pix_t        pixQ[$];
  int          addrQ[$];
  logic [15:0] mq[$];     // words the display should still see, in order
  bit          mb, mu;    // model byte select, model underflow

  // controller model state
  int ackLat, dataLat, gapPct, reqWait, dataWait, beatsDone, acceptCnt, lastAddr;
  bit inFlight, live, useWord0;
  logic [15:0] word0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus: controller, then the reference model.
  task automatic step(input bit fs, input bit pe, input bit rst = 1'b0);
    pix_t e;
    @(posedge clk); #2;
    FrameStart = fs; PixEn = pe; Rst = rst; burst_ack = 1'b0; rd_valid = 1'b0;
    if (inFlight) begin
      if (dataWait < dataLat) dataWait++;
      else if ($urandom_range(0, 99) >= gapPct) begin
        rd_valid = 1'b1;
        rd_data  = (useWord0 && lastAddr == 0 && beatsDone == 0) ? word0 : 16'($urandom);
        beatsDone++;
        if (beatsDone == BL) inFlight = 1'b0;
      end
    end else if (burst_req && !fs && !rst) begin
      if (reqWait < ackLat) reqWait++;
      else begin
        burst_ack = 1'b1; reqWait = 0; lastAddr = int'(burst_addr); acceptCnt++;
        inFlight = 1'b1; live = 1'b1; beatsDone = 0; dataWait = 0;
      end
    end
    if (rst) begin
      mq.delete(); mb = 1'b0; mu = 1'b0; addrQ.delete(); live = 1'b0;
    end else begin
      if (pe) begin
        if (mq.size() == 0) begin
          e.px = 8'h00; mu = 1'b1;
        end else begin
          e.px = mb ? mq[0][15:8] : mq[0][7:0];
          if (mb) void'(mq.pop_front());
          mb = !mb;
        end
        e.uf = mu;
        pixQ.push_back(e);
      end
      if (fs) begin
        mq.delete(); mb = 1'b0; addrQ.delete();
        for (int i = 0; i < WPF / BL; i++) addrQ.push_back(BASE + i * BL);
        if (inFlight) live = 1'b0;
      end else if (rd_valid && live) begin
        mq.push_back(rd_data);
        chk("fifo_bound", 32'(mq.size() <= DEPTH), 32'd1);
      end
    end
  endtask

  task automatic doReset();
    int n;
    n = 0;
    step(0, 0, 1); step(0, 0, 1);
    reqWait = 0;
    step(0, 0);
    @(negedge clk);
    chk("rst_pixel", 32'(Pixel), 32'h0);
    chk("rst_req", 32'(burst_req), 32'h0);
    chk("rst_addr", 32'(burst_addr), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    while (inFlight && n < 200) begin step(0, 0); n++; end
  endtask

  // Monitor: pops expected pixels one cycle after each PixEn, and expected
  // addresses on every accepted burst.
  initial begin
    bit   prevPe;
    pix_t e;
    prevPe = 1'b0;
    forever begin
      @(negedge clk);
      if (prevPe) begin
        if (pixQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL pixel_queue: got pixel %0h with nothing expected", Pixel);
        end else begin
          e = pixQ.pop_front();
          chk("pixel", 32'(Pixel), 32'(e.px));
          chk("underflow", 32'(underflow), 32'(e.uf));
        end
      end
      prevPe = PixEn && !Rst;
      if (burst_req && burst_ack) begin
        if (addrQ.size() == 0) begin
          checks++; failures++;
          $display("FAIL burst_extra: got request at %0h expected none", burst_addr);
        end else begin
          chk("burst_addr", 32'(burst_addr), 32'(addrQ.pop_front()));
        end
      end
      if (burst_req && !burst_ack && inFlight && live) begin
        checks++; failures++;
        $display("FAIL one_outstanding: got burst_req=1 expected 0 during burst");
      end
    end
  end

  initial begin
    int n;
    Rst = 1'b1; FrameStart = 1'b0; PixEn = 1'b0; burst_ack = 1'b0;
    rd_valid = 1'b0; rd_data = '0;
    ackLat = 0; dataLat = 0; gapPct = 0; reqWait = 0; dataWait = 0;
    beatsDone = 0; acceptCnt = 0; lastAddr = -1; inFlight = 0; live = 0;
    useWord0 = 0; word0 = '0; mb = 0; mu = 0;

    // Reset, then fill until the FIFO is full: two bursts, then WAIT.
    doReset();
    ackLat = 2; dataLat = 32; gapPct = 0; useWord0 = 1; word0 = 16'hBBAA;
    acceptCnt = 0;
    step(1, 0);
    repeat (250) step(0, 0);
    chk("A_bursts", 32'(acceptCnt), 32'd2);
    chk("A_wait_req", 32'(burst_req), 32'd0);
    step(0, 1); step(0, 1);                 // AA then BB
    repeat (4) step(0, 0);
    chk("A_still_wait", 32'(burst_req), 32'd0);
    repeat (62) step(0, 1);                 // down to 32 words
    repeat (10) step(0, 0);
    chk("A_refill", 32'(acceptCnt), 32'd3);
    useWord0 = 0;

    // Randomized traffic with occasional frame restarts.
    for (int seg = 0; seg < 3; seg++) begin
      int pixPct;
      pixPct  = (seg == 0) ? 20 : (seg == 1) ? 60 : 100;
      ackLat  = $urandom_range(0, 4);
      dataLat = $urandom_range(0, 6);
      gapPct  = $urandom_range(0, 30);
      step(1, 0);
      for (int c = 0; c < 1000; c++)
        step($urandom_range(0, 299) == 0, $urandom_range(0, 99) < pixPct);
    end

    // Underflow while the controller stalls; sticky until reset.
    doReset();
    ackLat = 1000;
    step(1, 0);
    step(0, 1);
    repeat (5) step(0, 0);
    chk("C_uf_held", 32'(underflow), 32'd1);
    step(0, 1);
    doReset();

    // FrameStart after beat 10: rest of the burst is dropped, restart at base.
    ackLat = 0; dataLat = 0; gapPct = 0;
    step(1, 0);
    n = 0;
    while (!(inFlight && beatsDone == 10) && n < 100) begin step(0, 0); n++; end
    chk("D_beat10", 32'(beatsDone), 32'd10);
    ackLat = 1000;
    step(1, 0);
    n = 0;
    while (inFlight && n < 100) begin step(0, 0); n++; end
    step(0, 0); step(0, 0);
    chk("D_rereq", 32'(burst_req), 32'd1);
    chk("D_addr", 32'(burst_addr), 32'(BASE));
    step(0, 1); step(0, 0);                 // FIFO must still be empty
    doReset();

    // Reset in the middle of a burst; remaining beats must be ignored.
    ackLat = 0;
    step(1, 0);
    n = 0;
    while (!(inFlight && beatsDone == 5) && n < 100) begin
      step(0, inFlight && beatsDone >= 2); n++;
    end
    step(0, 0, 1);
    step(0, 0);
    @(negedge clk);
    chk("E_pixel", 32'(Pixel), 32'h0);
    chk("E_req", 32'(burst_req), 32'h0);
    chk("E_underflow", 32'(underflow), 32'h0);
    repeat (4) step(0, 1);
    chk("E_no_req", 32'(burst_req), 32'h0);
    doReset();

    // Whole frame, zero-latency controller, continuous PixEn after prefill.
    ackLat = 0; dataLat = 0; gapPct = 0; acceptCnt = 0;
    step(1, 0);
    repeat (100) step(0, 0);
    repeat (WPF * 2) step(0, 1);
    repeat (20) step(0, 0);
    chk("F_bursts", 32'(acceptCnt), 32'(WPF / BL));
    chk("F_last_addr", 32'(lastAddr), 32'(BASE + WPF - BL));
    chk("F_underflow", 32'(underflow), 32'd0);
    chk("F_idle", 32'(burst_req), 32'd0);
    chk("F_addr_left", 32'(addrQ.size()), 32'd0);
    chk("F_pix_left", 32'(pixQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
